rect_fill_engine: RTL and testbench

// Parametrised raster fill engine driving the vga_adapter x/y/colour/plot port.

---
 rtl/vga_fill_pkg.sv | 18 +
 rtl/fill_xy_counter.sv | 45 ++++
 rtl/rect_fill_engine.sv | 156 +++++++++++++++
 tb/tb_rect_fill_engine.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_fill_pkg.sv
// Shared types and constants for the raster fill engine: FSM states, 3-bit RGB colours
// and the default screen geometry.
package vga_fill_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, DRAW, DONE} fill_state_t;

    localparam int unsigned DEFAULT_SCREEN_WIDTH  = 160;
    localparam int unsigned DEFAULT_SCREEN_HEIGHT = 120;

    // {R, G, B}
    localparam logic [2:0] BLACK  = 3'b000;
    localparam logic [2:0] BLUE   = 3'b001;
    localparam logic [2:0] GREEN  = 3'b010;
    localparam logic [2:0] YELLOW = 3'b110;
    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] WHITE  = 3'b111;

endpackage

// File: rtl/fill_xy_counter.sv
// Nested row-major x/y sweep counter: load a start corner, step one pixel per enabled
// cycle, wrap x back to the row start, and flag the bottom-right pixel.
module fill_xy_counter #(
    parameter int unsigned XW = 8,
    parameter int unsigned YW = 7
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          load_i,
    input  logic          step_i,
    input  logic [XW-1:0] x_load_i,
    input  logic [YW-1:0] y_load_i,
    input  logic [XW-1:0] x_start_i,
    input  logic [XW-1:0] x_end_i,
    input  logic [YW-1:0] y_end_i,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] y_o,
    output logic          last_o
);

    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_q <= '0;
            y_q <= '0;
        end else if (load_i) begin
            x_q <= x_load_i;
            y_q <= y_load_i;
        end else if (step_i) begin
            if (x_q == x_end_i) begin
                x_q <= x_start_i;
                y_q <= y_q + YW'(1);
            end else begin
                x_q <= x_q + XW'(1);
            end
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign last_o = (x_q == x_end_i) && (y_q == y_end_i);

endmodule

// File: rtl/rect_fill_engine.sv
// Clipped rectangle fill engine for the vga_adapter plot port (start/busy/done handshake).
// Define OUTLINE_MODE_EN to enable outline-only drawing selected by the mode input.
module rect_fill_engine
    import vga_fill_pkg::*;
#(
    parameter int unsigned SCREEN_WIDTH  = DEFAULT_SCREEN_WIDTH,
    parameter int unsigned SCREEN_HEIGHT = DEFAULT_SCREEN_HEIGHT,
    parameter int unsigned CW            = 3,
    parameter int unsigned XW            = $clog2(SCREEN_WIDTH),
    parameter int unsigned YW            = $clog2(SCREEN_HEIGHT)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic [XW-1:0] x0,
    input  logic [YW-1:0] y0,
    input  logic [XW-1:0] w,
    input  logic [YW-1:0] h,
    input  logic [CW-1:0] colour_in,
    input  logic          mode,
    input  logic          en,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic [CW-1:0] colour,
    output logic          plot,
    output logic          busy,
    output logic          done
);

    localparam logic [XW:0] XLim = (XW+1)'(SCREEN_WIDTH - 1);
    localparam logic [YW:0] YLim = (YW+1)'(SCREEN_HEIGHT - 1);
    localparam logic [XW:0] XOne = (XW+1)'(1);
    localparam logic [YW:0] YOne = (YW+1)'(1);

    fill_state_t state_q, state_d;

    logic [XW-1:0] x0_q, w_q, x_q, cx, x_end;
    logic [YW-1:0] y0_q, h_q, y_q, cy, y_end;
    logic [CW-1:0] fill_col_q, colour_q;
    logic          fin_q, plot_q, busy_q, done_q, busy_d, done_d;
    logic [XW:0]   x_far;
    logic [YW:0]   y_far;
    logic          empty, accept, emit, last, show;

    // Far edges are formed one bit wider so x0+w-1 cannot wrap before clipping.
    assign x_far  = {1'b0, x0_q} + {1'b0, w_q} - XOne;
    assign y_far  = {1'b0, y0_q} + {1'b0, h_q} - YOne;
    assign x_end  = (x_far > XLim) ? XLim[XW-1:0] : x_far[XW-1:0];
    assign y_end  = (y_far > YLim) ? YLim[YW-1:0] : y_far[YW-1:0];
    assign empty  = (w_q == '0) || (h_q == '0) || ({1'b0, x0_q} > XLim) || ({1'b0, y0_q} > YLim);

    assign accept = (state_q == IDLE) && start;
    // A pixel is consumed from the sweep on every enabled edge of LOAD (non-empty) and DRAW.
    assign emit   = en && (((state_q == LOAD) && !empty) || ((state_q == DRAW) && !fin_q));

`ifdef OUTLINE_MODE_EN
    logic mode_q;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mode_q <= 1'b0;
        end else if (accept) begin
            mode_q <= mode;
        end
    end
    // Edges are tested against the unclipped rectangle, so clipped-away sides vanish.
    assign show = !mode_q || (cx == x0_q) || ({1'b0, cx} == x_far)
                          || (cy == y0_q) || ({1'b0, cy} == y_far);
`else
    logic unused_mode;
    assign unused_mode = mode;
    assign show        = 1'b1;
`endif

    fill_xy_counter #(
        .XW(XW),
        .YW(YW)
    ) u_xy (
        .clk_i    (clk),
        .rst_ni   (resetn),
        .load_i   (accept),
        .step_i   (emit),
        .x_load_i (x0),
        .y_load_i (y0),
        .x_start_i(x0_q),
        .x_end_i  (x_end),
        .y_end_i  (y_end),
        .x_o      (cx),
        .y_o      (cy),
        .last_o   (last)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = LOAD;
            LOAD: state_d = empty ? DONE : DRAW;
            DRAW: if (fin_q) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == LOAD) || (state_d == DRAW);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x0_q       <= '0;
            y0_q       <= '0;
            w_q        <= '0;
            h_q        <= '0;
            fill_col_q <= '0;
            fin_q      <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            colour_q   <= '0;
            plot_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            if (accept) begin
                x0_q       <= x0;
                y0_q       <= y0;
                w_q        <= w;
                h_q        <= h;
                fill_col_q <= colour_in;
                fin_q      <= 1'b0;
            end else if (emit && last) begin
                fin_q <= 1'b1;
            end
            plot_q <= emit && show;
            if (emit && show) begin
                x_q      <= cx;
                y_q      <= cy;
                colour_q <= fill_col_q;
            end
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_rect_fill_engine.sv
// Self-checking bench for rect_fill_engine: directed and randomized rectangles compared
// against a pixel-list model built from the clipping/outline rules.
module tb_rect_fill_engine;
    import vga_fill_pkg::*;

    localparam int SW = 160;
    localparam int SH = 120;
`ifdef OUTLINE_MODE_EN
    localparam bit OutlineEn = 1'b1;
`else
    localparam bit OutlineEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       resetn, start, mode, en;
    logic [7:0] x0, w, x;
    logic [6:0] y0, h, y;
    logic [2:0] colour_in, colour;
    logic       plot, busy, done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int probe_x = -1;
    int probe_y = -1;
    logic [7:0] hold_x;
    logic [6:0] hold_y;
    logic [2:0] hold_c;

    // Sweep positions in row-major order and whether each one is plotted.
    int qx[$];
    int qy[$];
    bit qp[$];

    rect_fill_engine dut (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start),
        .x0       (x0),
        .y0       (y0),
        .w        (w),
        .h        (h),
        .colour_in(colour_in),
        .mode     (mode),
        .en       (en),
        .x        (x),
        .y        (y),
        .colour   (colour),
        .plot     (plot),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic build_model(input int rx0, input int ry0, input int rw, input int rh,
                               input int rmode);
        int xe, ye;
        bit outl;
        qx.delete();
        qy.delete();
        qp.delete();
        outl = OutlineEn && (rmode != 0);
        if (rw == 0 || rh == 0 || rx0 >= SW || ry0 >= SH) return;
        xe = (rx0 + rw - 1 > SW - 1) ? SW - 1 : rx0 + rw - 1;
        ye = (ry0 + rh - 1 > SH - 1) ? SH - 1 : ry0 + rh - 1;
        for (int yy = ry0; yy <= ye; yy++) begin
            for (int xx = rx0; xx <= xe; xx++) begin
                qx.push_back(xx);
                qy.push_back(yy);
                qp.push_back(!outl || xx == rx0 || xx == rx0 + rw - 1 ||
                             yy == ry0 || yy == ry0 + rh - 1);
            end
        end
    endtask

    // en_style: 0 = always 1, 1 = toggling, 2 = random. noise scrambles inputs and
    // pulses start while the engine is busy.
    task automatic run_rect(input string tag, input int rx0, input int ry0, input int rw,
                            input int rh, input int rcol, input int rmode,
                            input int en_style, input bit noise);
        int n0, npos, pos, plots, exp_plots, pix_err, hold_err, done_at, exp_done;
        int done_cnt, busy_cnt, limit, first_xy, last_xy, exp_first, exp_last, ex, ey;
        bit saw_probe, exp_probe, exp_plot, idle_ok, finished;

        build_model(rx0, ry0, rw, rh, rmode);
        npos = qx.size();
        exp_first = -1; exp_last = -1; exp_probe = 0; exp_plots = 0;
        for (int i = 0; i < npos; i++) begin
            if (qp[i]) begin
                exp_plots++;
                if (exp_first < 0) exp_first = qx[i] * 256 + qy[i];
                exp_last = qx[i] * 256 + qy[i];
                if (qx[i] == probe_x && qy[i] == probe_y) exp_probe = 1;
            end
        end
        plots = 0; pix_err = 0; hold_err = 0; done_at = -1; done_cnt = 0; busy_cnt = 0;
        first_xy = -1; last_xy = -1; saw_probe = 0; idle_ok = 0; finished = 0;
        ex = 0; ey = 0;

        x0 = 8'(rx0); y0 = 7'(ry0); w = 8'(rw); h = 7'(rh);
        colour_in = 3'(rcol); mode = rmode[0]; start = 1'b1;
        en = 1'($urandom_range(0, 1));
        n0 = cyc;
        exp_done = (npos == 0) ? n0 + 2 : -1;
        exp_plot = 0; pos = 0;
        limit = n0 + 8 * npos + 20;
        tick();
        while (!finished && cyc <= limit) begin
            if (plot !== exp_plot) pix_err++;
            if (plot) begin
                if (x !== 8'(ex) || y !== 7'(ey) || colour !== 3'(rcol)) pix_err++;
                plots++;
                if (first_xy < 0) first_xy = int'(x) * 256 + int'(y);
                last_xy = int'(x) * 256 + int'(y);
                if (int'(x) == probe_x && int'(y) == probe_y) saw_probe = 1;
                hold_x = x; hold_y = y; hold_c = colour;
            end else if (x !== hold_x || y !== hold_y || colour !== hold_c) begin
                hold_err++;
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = cyc;
            end
            if (done_at >= 0 && cyc == done_at + 2) begin
                idle_ok = !busy && !done && !plot;
                finished = 1;
            end else begin
                if (done_at >= 0 && cyc == done_at) start = 1'b1;
                else if (done_at >= 0) start = 1'b0;
                else start = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
                if (noise && done_at < 0) begin
                    x0 = 8'($urandom); y0 = 7'($urandom); w = 8'($urandom);
                    h = 7'($urandom); colour_in = 3'($urandom); mode = 1'($urandom);
                end
                case (en_style)
                    0: en = 1'b1;
                    1: en = (cyc % 2) == 0;
                    default: en = ($urandom_range(0, 3) != 0);
                endcase
                exp_plot = 0;
                if (en && pos < npos) begin
                    exp_plot = qp[pos];
                    ex = qx[pos];
                    ey = qy[pos];
                    pos++;
                    if (pos == npos) exp_done = cyc + 2;
                end
                tick();
            end
        end
        start = 1'b0;

        check({tag, ".done_seen"}, int'(done_at >= 0), 1);
        check({tag, ".pixels"}, pix_err, 0);
        check({tag, ".hold"}, hold_err, 0);
        check({tag, ".plots"}, plots, exp_plots);
        check({tag, ".first_xy"}, first_xy, exp_first);
        check({tag, ".last_xy"}, last_xy, exp_last);
        check({tag, ".done_cycle"}, done_at - n0, exp_done - n0);
        check({tag, ".done_width"}, done_cnt, 1);
        check({tag, ".busy_cycles"}, busy_cnt, exp_done - n0 - 1);
        check({tag, ".idle_after"}, int'(idle_ok), 1);
        check({tag, ".probe"}, int'(saw_probe), int'(exp_probe));
    endtask

    initial begin
        int bad;
        resetn = 1'b0; start = 1'b0; mode = 1'b0; en = 1'b0;
        x0 = '0; y0 = '0; w = '0; h = '0; colour_in = '0;
        hold_x = '0; hold_y = '0; hold_c = '0;
        repeat (3) tick();
        check("reset_outputs", int'({x, y, colour, plot, busy, done}), 0);
        resetn = 1'b1;
        tick();

        run_rect("full", 0, 0, 160, 120, int'(GREEN), 0, 0, 1'b0);
        run_rect("clip", 150, 115, 20, 10, int'(RED), 0, 0, 1'b0);
        run_rect("w_zero", 5, 5, 0, 10, int'(WHITE), 0, 0, 1'b0);
        run_rect("x0_off", 170, 5, 4, 4, int'(WHITE), 0, 2, 1'b1);
        run_rect("en_toggle", 10, 10, 4, 3, int'(BLUE), 0, 1, 1'b1);

        // Abort a sweep with reset: outputs clear asynchronously and no done follows.
        x0 = 8'd0; y0 = 7'd0; w = 8'd40; h = 7'd40; colour_in = WHITE; start = 1'b1;
        tick();
        start = 1'b0; en = 1'b1;
        repeat (10) tick();
        resetn = 1'b0;
        #1;
        check("reset_mid_draw", int'({x, y, colour, plot, busy, done}), 0);
        hold_x = '0; hold_y = '0; hold_c = '0;
        bad = 0;
        repeat (3) begin
            tick();
            if (done || busy || plot) bad++;
        end
        check("reset_no_done", bad, 0);
        resetn = 1'b1;
        tick();
        run_rect("post_reset", 3, 4, 6, 5, int'(YELLOW), 0, 2, 1'b0);

        probe_x = 22; probe_y = 31;
        run_rect("outline", 20, 30, 5, 4, int'(WHITE), 1, 0, 1'b0);
        probe_x = -1; probe_y = -1;

        for (int i = 0; i < 4; i++) begin
            run_rect("random", int'($urandom_range(0, 170)), int'($urandom_range(0, 127)),
                     int'($urandom_range(0, 40)), int'($urandom_range(0, 30)),
                     int'($urandom_range(0, 7)), int'($urandom_range(0, 1)), 2, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
